// File: rtl/memory_cycle.sv
// memory_cycle: M stage with req/ack data-memory handshake and M/W pipeline register.
// Optional MEM_MISALIGN_CHECK_EN turns misaligned memops into non-writing pass-throughs.
module memory_cycle #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic              MemWriteM,
  input  logic [4:0]        RdM,
  input  logic [31:0]       PCPlus4M,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              MisalignM,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [4:0]        RdW,
  output logic [31:0]       PCPlus4W,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic memOp, ackNow, misal, issue, wLoad;
  assign memOp = ValidM & (MemWriteM | ResultSrcM == 2'b01);
  assign ackNow = state == WAIT & mem_ack;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misal = state == IDLE & memOp & |ALU_ResultM[3:0];
`else
  assign misal = 1'b0;
`endif
  assign issue = state == IDLE & memOp & !misal;
  assign StallM = memOp & !ackNow & !misal;
  // W captures the M fields on a plain pass-through or on the completing ack edge
  assign wLoad = state == IDLE ? !issue : mem_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      MisalignM   <= 1'b0;
      ValidW      <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= '0;
      RdW         <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else begin
      MisalignM <= misal;
      ValidW    <= wLoad & (ValidM | ackNow);
      RegWriteW <= wLoad & RegWriteM & !misal;
      if (wLoad) begin
        ResultSrcW  <= ResultSrcM;
        RdW         <= RdM;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
      end
      if (issue) begin
        state     <= WAIT;
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= ALU_ResultM[ADDR_W-1:0];
        mem_wdata <= WriteDataM;
      end else if (ackNow) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        ReadDataW <= mem_we ? ReadDataW : mem_rdata;
      end
    end
  end
endmodule
